// File: rtl/qbus_dma_arb_if.sv
// Local Q-bus DMA arbitration signals: requester handshake plus the DMR/DMG/SACK bus side.
// All bus-side signals are active-high; pad inversion happens at chip top level.
interface qbus_dma_arb_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            bus_sync;
    logic            bus_rply;
    logic            bus_dmr;
    logic            bus_dmgi;
    logic            bus_dmgo;
    logic            bus_sack;
    logic            tmo_err;

    modport master (
        input  req,
        input  bus_sync,
        input  bus_rply,
        input  bus_dmgi,
        output gnt,
        output bus_dmr,
        output bus_dmgo,
        output bus_sack,
        output tmo_err
    );

    modport slave (
        output req,
        output bus_sync,
        output bus_rply,
        output bus_dmgi,
        input  gnt,
        input  bus_dmr,
        input  bus_dmgo,
        input  bus_sack,
        input  tmo_err
    );
endinterface

// File: rtl/qbus_dma_arb.sv
// Round-robin arbiter for on-board Q-bus DMA masters: raises DMR, completes DMG/SACK,
// grants one master at a time and passes unclaimed DMG downstream on DMGO.
module qbus_dma_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TMO  = 1023
) (
    input logic             clk,
    input logic             rst,
    qbus_dma_arb_if.master  bus
);
    localparam int unsigned TW = $clog2(TMO + 1);
    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAck,
        StOwn,
        StRel,
        StPass
    } state_e;

    state_e          state_q;
    logic [TW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;
    logic [NREQ-1:0] gnt_q;
    logic            dmr_q;
    logic            dmgo_q;
    logic            sack_q;
    logic            tmo_err_q;

    logic            any_req;
    logic [PW-1:0]   pick;
    logic            found;

    assign any_req = |bus.req;

    // First set request strictly after the last owner, wrapping around.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!found && bus.req[PW'((32'(ptr_q) + k) % NREQ)]) begin
                pick  = PW'((32'(ptr_q) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= PW'(NREQ - 1);
            win_q     <= '0;
            gnt_q     <= '0;
            dmr_q     <= 1'b0;
            dmgo_q    <= 1'b0;
            sack_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q <= StReq;
                        dmr_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else if (bus.bus_dmgi) begin
                        state_q <= StPass;
                        dmgo_q  <= 1'b1;
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + TW'(1);
                    // Grant beats timeout beats withdrawal when they coincide.
                    if (bus.bus_dmgi && any_req) begin
                        win_q   <= pick;
                        state_q <= StAck;
                        sack_q  <= 1'b1;
                        dmr_q   <= 1'b0;
                    end else if (bus.bus_dmgi) begin
                        state_q <= StPass;
                        dmr_q   <= 1'b0;
                        dmgo_q  <= 1'b1;
                    end else if (cnt_q == TW'(TMO - 1)) begin
                        state_q   <= StIdle;
                        dmr_q     <= 1'b0;
                        tmo_err_q <= 1'b1;
                    end else if (!any_req) begin
                        state_q <= StIdle;
                        dmr_q   <= 1'b0;
                    end
                end
                StAck: begin
                    // Previous master must be fully off the bus before the winner drives SYNC.
                    if (!bus.bus_dmgi && !bus.bus_sync && !bus.bus_rply) begin
                        state_q <= StOwn;
                        gnt_q   <= {{(NREQ - 1){1'b0}}, 1'b1} << win_q;
                    end
                end
                StOwn: begin
                    if (!bus.req[win_q]) begin
                        state_q <= StRel;
                        gnt_q   <= '0;
                        ptr_q   <= win_q;
                    end
                end
                StRel: begin
                    state_q <= StIdle;
                    sack_q  <= 1'b0;
                    gnt_q   <= '0;
                end
                StPass: begin
                    if (!bus.bus_dmgi) begin
                        state_q <= StIdle;
                        dmgo_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                    dmr_q   <= 1'b0;
                    dmgo_q  <= 1'b0;
                    sack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.bus_dmr  = dmr_q;
    assign bus.bus_dmgo = dmgo_q;
    assign bus.bus_sack = sack_q;
    assign bus.tmo_err  = tmo_err_q;
endmodule
